// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit with exception codes.
// Optional divider datapath is built only when MULTDIV_DIV_EN is defined.
//
// state | meaning
// IDLE  | waiting for ctrl_MULT / ctrl_DIV
// MUL   | one Booth iteration per cycle, WIDTH iterations
// DIV   | one restoring-division iteration per cycle, WIDTH iterations
// DONE  | final result/exception latched on exit, RDY pulses the following cycle

module multdiv_unit #(
  parameter int         WIDTH   = 32,
  parameter logic [4:0] EXC_REG = 5'd30
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [4:0]       in_reg,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy,
  output logic [4:0]       out_reg
);

  localparam int              CW        = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] CODE_OVF  = WIDTH'(4);
  localparam logic [WIDTH-1:0] CODE_DIVZ = WIDTH'(5);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_nxt;

  // acc is one bit wider than WIDTH so Booth add/sub of the most negative multiplicand cannot wrap
  logic [WIDTH:0]     acc;
  logic [WIDTH:0]     m;
  logic [WIDTH-1:0]   q;
  logic               q_m1;
  logic [CW-1:0]      cnt;
  logic               op_div;
  logic               div_zero;
  logic [4:0]         reg_q;

  logic               start_mul;
  logic               start_div;
  logic               div_bad;
  logic [WIDTH:0]     booth_sum;
  logic [2*WIDTH-1:0] product;
  logic               mul_ovf;

  assign start_mul = (state == IDLE) && ctrl_MULT;
  assign start_div = (state == IDLE) && !ctrl_MULT && ctrl_DIV;

`ifdef MULTDIV_DIV_EN
  logic               neg_q;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   quotient;

  assign div_bad  = (data_operandB == '0);
  assign a_mag    = data_operandA[WIDTH-1] ? (-data_operandA) : data_operandA;
  assign b_mag    = data_operandB[WIDTH-1] ? (-data_operandB) : data_operandB;
  assign rem_sh   = {acc[WIDTH-1:0], q[WIDTH-1]};
  assign rem_ge   = (rem_sh >= m);
  assign quotient = neg_q ? (-q) : q;
`else
  assign div_bad  = 1'b1;
`endif

  always_comb begin
    booth_sum = acc;
    case ({q[0], q_m1})
      2'b01:   booth_sum = acc + m;
      2'b10:   booth_sum = acc - m;
      default: booth_sum = acc;
    endcase
  end

  assign product = {acc[WIDTH-1:0], q};
  assign mul_ovf = !((&product[2*WIDTH-1:WIDTH-1]) || !(|product[2*WIDTH-1:WIDTH-1]));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_mul)      state_nxt = MUL;
        else if (start_div) state_nxt = div_bad ? DONE : DIV;
      end
      MUL:     if (cnt == CW'(1)) state_nxt = DONE;
      DIV:     if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc            <= '0;
      m              <= '0;
      q              <= '0;
      q_m1           <= 1'b0;
      cnt            <= '0;
      op_div         <= 1'b0;
      div_zero       <= 1'b0;
      reg_q          <= '0;
`ifdef MULTDIV_DIV_EN
      neg_q          <= 1'b0;
`endif
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      data_busy      <= 1'b0;
      out_reg        <= '0;
    end else begin
      data_resultRDY <= 1'b0;
      data_exception <= 1'b0;
      data_busy      <= start_mul || start_div || (state != IDLE);
      case (state)
        IDLE: begin
          if (start_mul) begin
            acc      <= '0;
            m        <= {data_operandA[WIDTH-1], data_operandA};
            q        <= data_operandB;
            q_m1     <= 1'b0;
            cnt      <= CW'(WIDTH);
            op_div   <= 1'b0;
            div_zero <= 1'b0;
            reg_q    <= in_reg;
          end else if (start_div) begin
            acc      <= '0;
            q_m1     <= 1'b0;
            cnt      <= CW'(WIDTH);
            op_div   <= 1'b1;
            div_zero <= div_bad;
            reg_q    <= in_reg;
`ifdef MULTDIV_DIV_EN
            m        <= {1'b0, b_mag};
            q        <= a_mag;
            neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
`endif
          end
        end
        MUL: begin
          acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          q    <= {booth_sum[0], q[WIDTH-1:1]};
          q_m1 <= q[0];
          cnt  <= cnt - CW'(1);
        end
        DIV: begin
`ifdef MULTDIV_DIV_EN
          acc <= rem_ge ? (rem_sh - m) : rem_sh;
          q   <= {q[WIDTH-2:0], rem_ge};
`endif
          cnt <= cnt - CW'(1);
        end
        DONE: begin
          data_resultRDY <= 1'b1;
          if (div_zero) begin
            data_result    <= CODE_DIVZ;
            data_exception <= 1'b1;
            out_reg        <= EXC_REG;
          end else if (!op_div && mul_ovf) begin
            data_result    <= CODE_OVF;
            data_exception <= 1'b1;
            out_reg        <= EXC_REG;
          end else begin
`ifdef MULTDIV_DIV_EN
            data_result <= op_div ? quotient : product[WIDTH-1:0];
`else
            data_result <= product[WIDTH-1:0];
`endif
            out_reg     <= reg_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit: latency, Booth products, overflow,
// divide (when MULTDIV_DIV_EN is defined) or divider-absent exception, start arbitration, reset abort.

module tb_multdiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [4:0]  in_reg;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        data_busy;
  logic [4:0]  out_reg;

  int total = 0;
  int bad   = 0;
  int lat;
  int n_rdy;
  logic [31:0] res_cap;

  multdiv_unit #(.WIDTH(32), .EXC_REG(5'd30)) dut (
    .clock          (clk),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .in_reg         (in_reg),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy),
    .out_reg        (out_reg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse a start for one edge; returns at the negedge of the first busy cycle with operands scrambled.
  task automatic start_op(input logic mul, input logic div, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r);
    @(negedge clk);
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    data_operandA = a;
    data_operandB = b;
    in_reg        = r;
    @(negedge clk);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    in_reg        = 5'd17;
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (data_resultRDY !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic count_rdy(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (data_resultRDY === 1'b1) n++;
    end
  endtask

  initial begin
    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0; in_reg = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", data_result, 32'h0);
    chk("rst_rdy",    32'(data_resultRDY), 32'h0);
    chk("rst_busy",   32'(data_busy), 32'h0);
    chk("rst_exc",    32'(data_exception), 32'h0);
    chk("rst_reg",    32'(out_reg), 32'h0);
    reset = 1'b0;

    // 7 * -6
    start_op(1'b1, 1'b0, 32'd7, -32'sd6, 5'd9);
    chk("t1_busy", 32'(data_busy), 32'h1);
    wait_rdy(lat);
    chk("t1_lat",    32'(lat), 32'd33);
    chk("t1_result", data_result, 32'hFFFF_FFD6);
    chk("t1_exc",    32'(data_exception), 32'h0);
    chk("t1_reg",    32'(out_reg), 32'd9);
    chk("t1_busy_rdy", 32'(data_busy), 32'h1);
    @(negedge clk);
    chk("t1_rdy_pulse", 32'(data_resultRDY), 32'h0);
    chk("t1_busy_end",  32'(data_busy), 32'h0);
    chk("t1_hold",      data_result, 32'hFFFF_FFD6);

    // 2^16 * 2^16 overflows
    start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd5);
    wait_rdy(lat);
    chk("t2_lat",    32'(lat), 32'd33);
    chk("t2_result", data_result, 32'd4);
    chk("t2_exc",    32'(data_exception), 32'h1);
    chk("t2_reg",    32'(out_reg), 32'd30);
    @(negedge clk);
    chk("t2_exc_clr", 32'(data_exception), 32'h0);

    // boundary products: -2^31 * 1 fits, -2^31 * -1 overflows, -1 * -1
    start_op(1'b1, 1'b0, 32'h8000_0000, 32'd1, 5'd2);
    wait_rdy(lat);
    chk("min_x1_result", data_result, 32'h8000_0000);
    chk("min_x1_exc",    32'(data_exception), 32'h0);
    start_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2);
    wait_rdy(lat);
    chk("min_xm1_result", data_result, 32'd4);
    chk("min_xm1_exc",    32'(data_exception), 32'h1);
    start_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12);
    wait_rdy(lat);
    chk("m1_x_m1_result", data_result, 32'd1);
    chk("m1_x_m1_reg",    32'(out_reg), 32'd12);

`ifdef MULTDIV_DIV_EN
    start_op(1'b0, 1'b1, -32'sd100, 32'd7, 5'd3);
    wait_rdy(lat);
    chk("t3_lat",    32'(lat), 32'd33);
    chk("t3_result", data_result, 32'hFFFF_FFF2);
    chk("t3_exc",    32'(data_exception), 32'h0);
    chk("t3_reg",    32'(out_reg), 32'd3);
    start_op(1'b0, 1'b1, 32'd55, 32'd0, 5'd3);
    wait_rdy(lat);
    chk("t3_dz_lat",    32'(lat), 32'd1);
    chk("t3_dz_result", data_result, 32'd5);
    chk("t3_dz_exc",    32'(data_exception), 32'h1);
    chk("t3_dz_reg",    32'(out_reg), 32'd30);
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    wait_rdy(lat);
    chk("div_wrap_result", data_result, 32'h8000_0000);
    chk("div_wrap_exc",    32'(data_exception), 32'h0);
    start_op(1'b0, 1'b1, 32'd7, -32'sd2, 5'd8);
    wait_rdy(lat);
    chk("div_trunc_result", data_result, 32'hFFFF_FFFD);
`else
    start_op(1'b0, 1'b1, 32'd10, 32'd2, 5'd3);
    wait_rdy(lat);
    chk("t6_lat",    32'(lat), 32'd1);
    chk("t6_result", data_result, 32'd5);
    chk("t6_exc",    32'(data_exception), 32'h1);
    chk("t6_reg",    32'(out_reg), 32'd30);
`endif

    // simultaneous starts: MULT wins; a later MULT while busy is ignored
    start_op(1'b1, 1'b1, 32'd3, 32'd5, 5'd6);
    n_rdy = 0;
    res_cap = '0;
    for (int i = 0; i < 60; i++) begin
      if (i == 9) begin
        ctrl_MULT = 1'b1; data_operandA = 32'd100; data_operandB = 32'd100;
      end else begin
        ctrl_MULT = 1'b0;
      end
      @(negedge clk);
      if (data_resultRDY === 1'b1) begin
        n_rdy++;
        res_cap = data_result;
      end
    end
    ctrl_MULT = 1'b0;
    chk("t4_rdy_count", 32'(n_rdy), 32'd1);
    chk("t4_result",    res_cap, 32'd15);

    // start presented in the DONE-state cycle is ignored
    start_op(1'b1, 1'b0, 32'd6, 32'd7, 5'd4);
    repeat (32) @(negedge clk);
    ctrl_MULT = 1'b1; data_operandA = 32'd1; data_operandB = 32'd1;
    @(negedge clk);
    ctrl_MULT = 1'b0;
    chk("done_rdy",    32'(data_resultRDY), 32'h1);
    chk("done_result", data_result, 32'd42);
    count_rdy(40, n_rdy);
    chk("done_start_ignored", 32'(n_rdy), 32'd0);

    // start presented during the RDY cycle is accepted
    start_op(1'b1, 1'b0, 32'd6, 32'd7, 5'd4);
    wait_rdy(lat);
    ctrl_MULT = 1'b1; data_operandA = -32'sd3; data_operandB = 32'd3; in_reg = 5'd11;
    @(negedge clk);
    ctrl_MULT = 1'b0;
    chk("b2b_busy", 32'(data_busy), 32'h1);
    wait_rdy(lat);
    chk("b2b_lat",    32'(lat), 32'd33);
    chk("b2b_result", data_result, 32'hFFFF_FFF7);
    chk("b2b_reg",    32'(out_reg), 32'd11);

    // reset mid-multiply aborts with no RDY
    start_op(1'b1, 1'b0, 32'd9, 32'd9, 5'd7);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_result", data_result, 32'h0);
    chk("t5_busy",   32'(data_busy), 32'h0);
    chk("t5_rdy",    32'(data_resultRDY), 32'h0);
    chk("t5_reg",    32'(out_reg), 32'h0);
    reset = 1'b0;
    count_rdy(40, n_rdy);
    chk("t5_no_rdy", 32'(n_rdy), 32'd0);
    start_op(1'b1, 1'b0, 32'd2, 32'd2, 5'd1);
    wait_rdy(lat);
    chk("t5_lat",    32'(lat), 32'd33);
    chk("t5_result2", data_result, 32'd4);
    chk("t5_exc2",   32'(data_exception), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
